board_input_cond: RTL and testbench

Parametrised board-input conditioner between the FPGA pins (slide switches, push buttons) and the core's CR_MEM input registers and reset logic. Per channel it normalises polarity, synchronises to `Clock`, debounces, and produces single-cycle rise, fall and long-hold event pulses. It supersedes raw pin-to-core wiring and generalises to any channel count, debounce time and per-channel polarity.

---
 rtl/board_io_pkg.sv | 23 ++
 rtl/input_cond_ch.sv | 99 +++++++++
 rtl/board_input_cond.sv | 45 ++++
 tb/tb_board_input_cond.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Board-level constants and helpers shared by the input-conditioning blocks.
// DE10-Lite defaults: 10 slide switches followed by 2 active-low push buttons.
package board_io_pkg;

  localparam int BOARD_NUM_SW  = 10;
  localparam int BOARD_NUM_BTN = 2;
  localparam int BOARD_NUM_CH  = BOARD_NUM_SW + BOARD_NUM_BTN;
  localparam int CLK_HZ        = 50_000_000;

  // Buttons sit in the top two bits and idle high on the board.
  localparam logic [BOARD_NUM_CH-1:0] BOARD_ACTIVE_LOW_MASK = 12'hC00;

  typedef struct packed {
    logic rise;
    logic fall;
    logic hold;
  } ch_evt_t;

  function automatic int ms_to_cycles(int ms);
    return ms * (CLK_HZ / 1000);
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One board-input channel: polarity fix, synchroniser, debounce and hold
// detection, producing a clean level plus single-cycle event pulses.
module input_cond_ch
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 10,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    raw_i,
  output logic    level_o,
  output ch_evt_t evt_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   hold_w;
  logic                   mismatch, settle;

  // Only the first stage sees the asynchronous pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i ^ ACTIVE_LOW};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Any reversion to the current level restarts the count from zero.
  always_comb begin
    mismatch = (sync != level_q);
    settle   = mismatch && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
    db_cnt_d = '0;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (settle) begin
      level_d = sync;
      rise_d  = sync;
      fall_d  = ~sync;
    end else if (mismatch) begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  if (HOLD_CYCLES > 0) begin : g_hold
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_q, hold_d;

    // A fall landing on the saturation edge suppresses the hold event.
    always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (!level_q)                            hold_cnt_d = '0;
      else if (hold_cnt_q != HW'(HOLD_CYCLES)) hold_cnt_d = hold_cnt_q + HW'(1);
      hold_d = level_q && !fall_d && (hold_cnt_q == HW'(HOLD_CYCLES - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_cnt_q <= '0;
        hold_q     <= 1'b0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
        hold_q     <= hold_d;
      end
    end

    assign hold_w = hold_q;
  end else begin : g_nohold
    assign hold_w = 1'b0;
  end

  assign level_o = level_q;
  assign evt_o   = '{rise: rise_q, fall: fall_q, hold: hold_w};

endmodule

// File: rtl/board_input_cond.sv
// Conditions raw board switches/buttons into debounced levels and event
// pulses for the core; one independent channel per pin.
module board_input_cond
  import board_io_pkg::*;
#(
  parameter int                NUM_CH          = BOARD_NUM_CH,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 1_000_000,
  parameter int                HOLD_CYCLES     = 50_000_000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = NUM_CH'(BOARD_ACTIVE_LOW_MASK)
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] RawIn,
  output logic [NUM_CH-1:0] Level,
  output logic [NUM_CH-1:0] RisePulse,
  output logic [NUM_CH-1:0] FallPulse,
  output logic [NUM_CH-1:0] HoldPulse,
  output logic              AnyEvent
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_evt_t evt;

    input_cond_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clk_i  (Clock),
      .rst_ni (Rst),
      .raw_i  (RawIn[i]),
      .level_o(Level[i]),
      .evt_o  (evt)
    );

    assign RisePulse[i] = evt.rise;
    assign FallPulse[i] = evt.fall;
    assign HoldPulse[i] = evt.hold;
  end

  assign AnyEvent = |(RisePulse | FallPulse);

endmodule

// File: tb/tb_board_input_cond.sv
// Directed bench for board_input_cond with a window-based reference model
// checked every cycle, plus literal timing expectations per scenario.
module tb_board_input_cond;

  localparam int             NUM_CH = 4;
  localparam int             SYNC   = 2;
  localparam int             DB     = 4;
  localparam int             HOLD   = 10;
  localparam logic [3:0]     MASK   = 4'b1000;
  localparam int             HN     = SYNC + DB - 1;

  logic              Clock = 1'b0;
  logic              Rst   = 1'b0;
  logic [NUM_CH-1:0] RawIn = 4'b1000;
  logic [NUM_CH-1:0] Level, RisePulse, FallPulse, HoldPulse;
  logic              AnyEvent;
  logic [NUM_CH-1:0] Level2, Rise2, Fall2, Hold2;
  logic              Any2;

  int tests = 0;
  int fails = 0;

  board_input_cond #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD), .ACTIVE_LOW_MASK(MASK)
  ) dut (
    .Clock(Clock), .Rst(Rst), .RawIn(RawIn), .Level(Level),
    .RisePulse(RisePulse), .FallPulse(FallPulse), .HoldPulse(HoldPulse),
    .AnyEvent(AnyEvent)
  );

  board_input_cond #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(0), .ACTIVE_LOW_MASK(MASK)
  ) dut_nohold (
    .Clock(Clock), .Rst(Rst), .RawIn(RawIn), .Level(Level2),
    .RisePulse(Rise2), .FallPulse(Fall2), .HoldPulse(Hold2),
    .AnyEvent(Any2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Reference model: Level flips once the last DB synchronised samples all
  // disagree with it; hold fires when Level has been 1 for HOLD+1 sampled cycles.
  logic [NUM_CH-1:0] hist [HN];
  logic [NUM_CH-1:0] m_lvl, m_rise, m_fall, m_hold;
  int                hrun [NUM_CH];
  bit                diff;

  task mclear();
    for (int k = 0; k < HN; k++) hist[k] = '0;
    m_lvl = '0; m_rise = '0; m_fall = '0; m_hold = '0;
    for (int c = 0; c < NUM_CH; c++) hrun[c] = 0;
  endtask

  initial begin
    mclear();
    forever begin
      @(posedge Clock or negedge Rst);
      if (!Rst) mclear();
      else begin
        for (int c = 0; c < NUM_CH; c++) begin
          diff = 1'b1;
          for (int k = SYNC - 1; k <= SYNC + DB - 2; k++)
            if (hist[k][c] == m_lvl[c]) diff = 1'b0;
          m_rise[c] = diff & ~m_lvl[c];
          m_fall[c] = diff &  m_lvl[c];
          if (diff) m_lvl[c] = ~m_lvl[c];
          hrun[c]   = m_lvl[c] ? hrun[c] + 1 : 0;
          m_hold[c] = (HOLD > 0) && (hrun[c] == HOLD + 1);
        end
        for (int k = HN - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = RawIn ^ MASK;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clock);
      chk("level",     Level,     m_lvl);
      chk("rise",      RisePulse, m_rise);
      chk("fall",      FallPulse, m_fall);
      chk("hold",      HoldPulse, m_hold);
      chk("any",       AnyEvent,  |(m_rise | m_fall));
      chk("level_h0",  Level2,    m_lvl);
      chk("rise_h0",   Rise2,     m_rise);
      chk("fall_h0",   Fall2,     m_fall);
      chk("hold_h0",   Hold2,     4'b0000);
      chk("any_h0",    Any2,      |(m_rise | m_fall));
    end
  end

  int nr, nf, nh;

  initial begin
    // reset state
    step(3);
    chk("rst_level", Level, 4'b0000);
    chk("rst_rise",  RisePulse, 4'b0000);
    chk("rst_any",   AnyEvent, 1'b0);
    Rst = 1'b1;
    step(10);
    chk("idle_level", Level, 4'b0000);

    // clean rise on ch0, then hold exactly HOLD cycles after the rise pulse
    RawIn[0] = 1'b1;
    step(5); chk("t1_level_early", Level[0], 1'b0);
    step(1); chk("t1_level", Level[0], 1'b1);
    chk("t1_rise", RisePulse[0], 1'b1);
    chk("t1_any",  AnyEvent, 1'b1);
    step(1); chk("t1_rise_once", RisePulse[0], 1'b0);
    step(8); chk("t1_hold_early", HoldPulse[0], 1'b0);
    step(1); chk("t1_hold", HoldPulse[0], 1'b1);
    step(1); chk("t1_hold_once", HoldPulse[0], 1'b0);
    RawIn[0] = 1'b0;
    step(6); chk("t1_fall", FallPulse[0], 1'b1);
    chk("t1_level_low", Level[0], 1'b0);
    step(12);

    // bounce on ch1: four 2-cycle segments, then stable high
    nr = 0; nf = 0;
    for (int s = 0; s < 4; s++) begin
      RawIn[1] = ~s[0];
      for (int j = 0; j < 2; j++) begin
        step(1); nr += RisePulse[1]; nf += FallPulse[1];
      end
    end
    RawIn[1] = 1'b1;
    step(5); nr += RisePulse[1]; nf += FallPulse[1];
    chk("t2_level_early", Level[1], 1'b0);
    step(1); nr += RisePulse[1]; nf += FallPulse[1];
    chk("t2_rise", RisePulse[1], 1'b1);
    chk("t2_rise_count", nr, 1);
    chk("t2_no_fall", nf, 0);
    RawIn[1] = 1'b0;
    step(12);

    // active-low button ch3
    chk("t3_idle", Level[3], 1'b0);
    RawIn[3] = 1'b0;
    step(6);  chk("t3_rise", RisePulse[3], 1'b1);
    step(10); chk("t3_hold", HoldPulse[3], 1'b1);
    step(4);  RawIn[3] = 1'b1;
    step(6);  chk("t3_fall", FallPulse[3], 1'b1);
    step(12);

    // hold boundary on ch2: Level high 9 cycles, then 10 (fall wins)
    for (int len = 9; len <= 10; len++) begin
      nh = 0;
      RawIn[2] = 1'b1;
      for (int j = 0; j < len; j++) begin step(1); nh += HoldPulse[2]; end
      RawIn[2] = 1'b0;
      for (int j = 0; j < 6; j++) begin step(1); nh += HoldPulse[2]; end
      chk("t4_fall", FallPulse[2], 1'b1);
      chk("t4_no_hold", nh, 0);
      step(12);
    end

    // all channels at once
    RawIn = 4'b0111;
    step(6); chk("t5_rise_all", RisePulse, 4'b1111);
    chk("t5_any", AnyEvent, 1'b1);
    step(1); chk("t5_any_once", AnyEvent, 1'b0);
    chk("t5_level_all", Level, 4'b1111);
    RawIn = 4'b1000;
    step(6); chk("t5_fall_all", FallPulse, 4'b1111);
    step(12);

    // reset mid-operation: ch0 at level 1, ch1 mid-count at 3
    RawIn[0] = 1'b1;
    step(6); chk("t6_level0", Level[0], 1'b1);
    RawIn[1] = 1'b1;
    step(5);
    #2 Rst = 1'b0;
    #1;
    chk("t6_rst_level", Level, 4'b0000);
    chk("t6_rst_rise",  RisePulse, 4'b0000);
    chk("t6_rst_fall",  FallPulse, 4'b0000);
    chk("t6_rst_hold",  HoldPulse, 4'b0000);
    chk("t6_rst_any",   AnyEvent, 1'b0);
    step(3);
    Rst = 1'b1;
    step(5); chk("t6_level_early", Level, 4'b0000);
    step(1); chk("t6_rise", RisePulse, 4'b0011);
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
